// File: rtl/sram22_param_model.sv
// Parametrised single-port SRAM22 behavioural model with post-reset clear sweep and read-valid flag.
// Latency: write commits on the accepting edge; read data appears READ_LATENCY edges after accept (1 = same edge).
// Backpressure: busy high during the clear sweep; requests presented then are dropped, in-flight reads still drain.
module sram22_param_model #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int WMASK_WIDTH    = 4,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   ce,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid,
  output logic                   busy
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int LANE_W    = DATA_WIDTH / WMASK_WIDTH;

  // Illegal parameter combinations stop elaboration rather than silently mis-modelling.
  if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
    $fatal(1, "sram22_param_model: DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_lat
    $fatal(1, "sram22_param_model: READ_LATENCY must be 1..3");
  end

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
  localparam logic   RST_BUSY  = (CLEAR_ON_RESET != 0);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;

  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

  logic                    rd_vld [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   rd_dat [READ_LATENCY];

  logic                    rd_acc;
  logic                    wr_acc;
  logic                    clr_wr;

  // Requests only count when the sweep is finished; clear writes are suppressed while reset is held
  // so that reset alone never alters the array.
  assign rd_acc = ce & ~we & ~busy;
  assign wr_acc = ce &  we & ~busy;
  assign clr_wr = busy & rstb;

  // Clear sequencer: walk every address once after reset, dropping busy on the edge that writes the last word.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= RST_STATE;
      busy    <= RST_BUSY;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state <= ST_READY;
            busy  <= 1'b0;
          end
        end
        ST_READY: begin
          busy <= 1'b0;
        end
        default: begin
          state <= ST_READY;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: clear sweep has priority, otherwise lane-masked writes; no reset on the contents.
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem[clr_cnt] <= '0;
    end else if (wr_acc) begin
      for (int k = 0; k < WMASK_WIDTH; k++) begin
        if (wmask[k]) begin
          mem[addr][k*LANE_W +: LANE_W] <= din[k*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Read pipeline: stage 0 samples the array on the accepting edge; data stages only move with a valid
  // so the last stage doubles as the hold-last-value output register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        rd_vld[i] <= 1'b0;
        rd_dat[i] <= '0;
      end
    end else begin
      rd_vld[0] <= rd_acc;
      if (rd_acc) begin
        rd_dat[0] <= mem[addr];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_vld[i] <= rd_vld[i-1];
        if (rd_vld[i-1]) begin
          rd_dat[i] <= rd_dat[i-1];
        end
      end
    end
  end

  assign dout       = rd_dat[READ_LATENCY-1];
  assign dout_valid = rd_vld[READ_LATENCY-1];

endmodule
